wave_rom_scheduler: RTL

Round-robin request/grant scheduler that shares one single-port wave_rom between N_REQ wave generators.
- Requesters are served only when they ask, instead of through a fixed time slot each.
- Pipelines up to one ROM read per cycle and routes each returned sample to its originator with a one-cycle valid pulse.
- Sits between the oscillator bank and wave_rom; it replaces fixed slot polling in the memory subsystem.

---
 rtl/wave_rom_scheduler.sv | 94 +++++++++
 1 files changed

// File: rtl/wave_rom_scheduler.sv
// Round-robin arbiter sharing one single-port wave ROM among N_REQ requesters.
// Grant is combinational; each sample returns ROM_LATENCY+1 cycles after its grant; responses cannot be stalled.
module wave_rom_scheduler #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int N_REQ       = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst_n,
  input  logic [N_REQ-1:0]                     req,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
  output logic [N_REQ-1:0]                     gnt,
  output logic [N_REQ-1:0]                     rsp_valid,
  output logic [N_REQ-1:0][DATA_WIDTH-1:0]     rsp_data,
  output logic                                 rom_en,
  output logic [ADDR_WIDTH-1:0]                rom_addr,
  input  logic [DATA_WIDTH-1:0]                rom_data
);

  localparam int            PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic          grant_any;
  logic [PW:0]   scan;

  logic [ROM_LATENCY-1:0]           tag_vld_q;
  logic [ROM_LATENCY-1:0][PW-1:0]   tag_idx_q;
  logic [N_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Scan from ptr upward; the explicit subtract keeps the wrap exact for non-power-of-two N_REQ.
  always_comb begin
    win       = '0;
    grant_any = 1'b0;
    scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan >= (PW+1)'(N_REQ)) begin
        scan = scan - (PW+1)'(N_REQ);
      end
      if (!grant_any && req[scan[PW-1:0]]) begin
        grant_any = 1'b1;
        win       = scan[PW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (grant_any) begin
      gnt[win] = 1'b1;
    end
  end

  assign ptr_d    = grant_any ? ((win == LAST) ? '0 : win + PW'(1)) : ptr_q;
  assign rom_en   = |req;
  assign rom_addr = grant_any ? req_addr[win] : '0;

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[ROM_LATENCY-1]) begin
      rsp_valid_d[tag_idx_q[ROM_LATENCY-1]] = 1'b1;
      rsp_data_d[tag_idx_q[ROM_LATENCY-1]]  = rom_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      tag_vld_q[0] <= grant_any;
      tag_idx_q[0] <= win;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
